mem_lsu: RTL and testbench

- Memory-access stage directly downstream of the execute stage.
- Consumes execute results: inst type, rd enable/address/data, load/store select and address.
- Performs load/store over a single req/ack data-memory port.
- Hands a registered writeback bundle to the writeback stage.
- Raises a stall request to ctrl while a memory transaction is outstanding.

---
 rtl/mem_lsu_pkg.sv | 32 +++
 rtl/mem_lsu_align.sv | 56 +++++
 rtl/mem_lsu.sv | 142 ++++++++++++++
 tb/tb_mem_lsu.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the memory-access stage: ls_sel funct3 codes, inst_type
// bit positions, FSM states and common constants.
package mem_lsu_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_D  = 3'b011;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;
  localparam logic [2:0] LS_WU = 3'b110;

  localparam int TYPE_STORE = 0;
  localparam int TYPE_LOAD  = 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [63:0] ZEROWORD = 64'h0;
  localparam logic        ENABLE   = 1'b1;
  localparam logic        DISABLE  = 1'b0;

  function automatic logic is_misaligned(input logic [2:0] sel, input logic [2:0] off);
    case (sel)
      LS_H, LS_HU: return off[0];
      LS_W, LS_WU: return |off[1:0];
      LS_D:        return |off;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering for the data port: store mask/data replication and
// load extraction with sign or zero extension.
module lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      ls_sel,
  input  logic [2:0]      byte_off,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [7:0]      wmask,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    wmask     = 8'hFF;
    wdata     = store_data;
    load_data = '0;
    shifted   = rdata >> {byte_off, 3'b000};

    // Replicated store data lets the memory pick any lane using the mask alone
    case (ls_sel)
      LS_B, LS_BU: begin
        wmask = 8'h01 << byte_off;
        wdata = {(XLEN/8){store_data[7:0]}};
      end
      LS_H, LS_HU: begin
        wmask = 8'h03 << byte_off;
        wdata = {(XLEN/16){store_data[15:0]}};
      end
      LS_W, LS_WU: begin
        wmask = 8'h0F << byte_off;
        wdata = {(XLEN/32){store_data[31:0]}};
      end
      default: begin
        wmask = 8'hFF;
        wdata = store_data;
      end
    endcase

    case (ls_sel)
      LS_B:    load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LS_H:    load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LS_W:    load_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      LS_BU:   load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      LS_HU:   load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      LS_WU:   load_data = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage: runs one load/store at a time over a req/ack port,
// stalls upstream while it is outstanding and registers the writeback bundle.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int TYPE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TYPE_W-1:0] inst_type_i,
  input  logic              rd_ena_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [XLEN-1:0]   rd_data_i,
  input  logic [2:0]        ls_sel_i,
  input  logic [XLEN-1:0]   ls_addr_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [7:0]        mem_wmask_o,
  input  logic              mem_ack_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic [TYPE_W-1:0] wb_inst_type_o,
  output logic              wb_rd_ena_o,
  output logic [4:0]        wb_rd_addr_o,
  output logic [XLEN-1:0]   wb_rd_data_o,
  output logic              mem_stall_req,
  output logic              misalign_o
);

  logic [0:0]        state;
  logic [2:0]        sel_p1;
  logic [2:0]        off_p1;
  logic [4:0]        rd_addr_p1;
  logic              rd_ena_p1;
  logic              load_p1;
  logic [TYPE_W-1:0] type_p1;

  logic              is_load;
  logic              is_store;
  logic              is_mem;
  logic              bad_align;
  logic              start;
  logic              reject;
  logic [2:0]        align_sel;
  logic [2:0]        align_off;
  logic [7:0]        align_wmask;
  logic [XLEN-1:0]   align_wdata;
  logic [XLEN-1:0]   align_load;

  // Load wins when both type bits are set
  assign is_load   = inst_type_i[TYPE_LOAD];
  assign is_store  = inst_type_i[TYPE_STORE] & ~inst_type_i[TYPE_LOAD];
  assign is_mem    = is_load | is_store;
  assign bad_align = is_misaligned(ls_sel_i, ls_addr_i[2:0]);
  assign start     = (state == ST_IDLE) & is_mem & ~bad_align;
  assign reject    = (state == ST_IDLE) & is_mem & bad_align;

  assign mem_stall_req = start | ((state == ST_WAIT) & ~mem_ack_i);

  // One aligner serves both directions: live inputs in IDLE, latched fields in WAIT
  assign align_sel = (state == ST_WAIT) ? sel_p1 : ls_sel_i;
  assign align_off = (state == ST_WAIT) ? off_p1 : ls_addr_i[2:0];

  lsu_align #(.XLEN(XLEN)) u_align (
    .ls_sel     (align_sel),
    .byte_off   (align_off),
    .store_data (rd_data_i),
    .rdata      (mem_rdata_i),
    .wmask      (align_wmask),
    .wdata      (align_wdata),
    .load_data  (align_load)
  );

  // p0 -> p1: capture the accepted request for the WAIT phase
  always_ff @(posedge clk) begin
    if (start) begin
      sel_p1     <= ls_sel_i;
      off_p1     <= ls_addr_i[2:0];
      rd_addr_p1 <= rd_addr_i;
      rd_ena_p1  <= rd_ena_i;
      load_p1    <= is_load;
      type_p1    <= inst_type_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      mem_req_o      <= DISABLE;
      mem_we_o       <= DISABLE;
      mem_addr_o     <= ZEROWORD;
      mem_wdata_o    <= ZEROWORD;
      mem_wmask_o    <= '0;
      wb_inst_type_o <= '0;
      wb_rd_ena_o    <= DISABLE;
      wb_rd_addr_o   <= '0;
      wb_rd_data_o   <= ZEROWORD;
      misalign_o     <= DISABLE;
    end else begin
      misalign_o     <= DISABLE;
      wb_inst_type_o <= '0;
      wb_rd_ena_o    <= DISABLE;
      wb_rd_addr_o   <= '0;
      wb_rd_data_o   <= ZEROWORD;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_WAIT;
            mem_req_o   <= ENABLE;
            mem_we_o    <= is_store;
            mem_addr_o  <= {ls_addr_i[XLEN-1:3], 3'b000};
            mem_wdata_o <= align_wdata;
            mem_wmask_o <= align_wmask;
          end else if (reject) begin
            misalign_o <= ENABLE;
          end else begin
            wb_inst_type_o <= inst_type_i;
            wb_rd_ena_o    <= rd_ena_i;
            wb_rd_addr_o   <= rd_addr_i;
            wb_rd_data_o   <= rd_data_i;
          end
        end
        ST_WAIT: begin
          if (mem_ack_i) begin
            state          <= ST_IDLE;
            mem_req_o      <= DISABLE;
            mem_we_o       <= DISABLE;
            mem_wmask_o    <= '0;
            wb_inst_type_o <= type_p1;
            wb_rd_addr_o   <= rd_addr_p1;
            wb_rd_ena_o    <= load_p1 & rd_ena_p1;
            wb_rd_data_o   <= load_p1 ? align_load : ZEROWORD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: single-cycle vector table plus hand-run
// load/store, wait-state and reset-abort sequences.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  inst_type_i;
  logic        rd_ena_i;
  logic [4:0]  rd_addr_i;
  logic [63:0] rd_data_i;
  logic [2:0]  ls_sel_i;
  logic [63:0] ls_addr_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_wmask_o;
  logic        mem_ack_i;
  logic [63:0] mem_rdata_i;
  logic [7:0]  wb_inst_type_o;
  logic        wb_rd_ena_o;
  logic [4:0]  wb_rd_addr_o;
  logic [63:0] wb_rd_data_o;
  logic        mem_stall_req;
  logic        misalign_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk            (clk),
    .rst            (rst),
    .inst_type_i    (inst_type_i),
    .rd_ena_i       (rd_ena_i),
    .rd_addr_i      (rd_addr_i),
    .rd_data_i      (rd_data_i),
    .ls_sel_i       (ls_sel_i),
    .ls_addr_i      (ls_addr_i),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_wmask_o    (mem_wmask_o),
    .mem_ack_i      (mem_ack_i),
    .mem_rdata_i    (mem_rdata_i),
    .wb_inst_type_o (wb_inst_type_o),
    .wb_rd_ena_o    (wb_rd_ena_o),
    .wb_rd_addr_o   (wb_rd_addr_o),
    .wb_rd_data_o   (wb_rd_data_o),
    .mem_stall_req  (mem_stall_req),
    .misalign_o     (misalign_o)
  );

  typedef struct {
    logic [7:0]  typ;
    logic        ena;
    logic [4:0]  ra;
    logic [63:0] rd;
    logic [2:0]  sel;
    logic [63:0] addr;
    logic        ack;
    logic [7:0]  e_typ;
    logic        e_ena;
    logic [4:0]  e_ra;
    logic [63:0] e_rd;
    logic        e_stall;
    logic        e_mis;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_type_i = 8'h00;
    rd_ena_i    = 1'b0;
    rd_addr_i   = 5'd0;
    rd_data_i   = 64'h0;
    ls_sel_i    = 3'b000;
    ls_addr_i   = 64'h0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 64'h0;
  endtask

  // Issue one aligned access, hold ack off for 'waits' cycles, then ack once.
  task automatic run_mem(input string nm, input logic [7:0] typ, input logic [2:0] sel,
                         input logic [63:0] addr, input logic [63:0] data, input logic [4:0] ra,
                         input int waits, input logic [63:0] rdata, input logic is_st,
                         input logic [7:0] e_mask, input logic [63:0] e_wdata,
                         input logic e_ena, input logic [63:0] e_rd, input int e_stalls);
    int stalls;
    logic [63:0] held_addr;
    stalls = 0;
    inst_type_i = typ; rd_ena_i = 1'b1; rd_addr_i = ra; rd_data_i = data;
    ls_sel_i = sel; ls_addr_i = addr; mem_ack_i = 1'b0; mem_rdata_i = 64'h0;
    #1;
    if (mem_stall_req) stalls++;
    step();
    chk({nm, " req"}, 64'(mem_req_o), 64'(1'b1));
    chk({nm, " we"}, 64'(mem_we_o), 64'(is_st));
    chk({nm, " addr"}, mem_addr_o, {addr[63:3], 3'b000});
    if (is_st) begin
      chk({nm, " wmask"}, 64'(mem_wmask_o), 64'(e_mask));
      chk({nm, " wdata"}, mem_wdata_o, e_wdata);
    end
    chk({nm, " accept bubble"}, 64'(wb_rd_ena_o), 64'(1'b0));
    held_addr = mem_addr_o;
    for (int w = 0; w < waits; w++) begin
      if (mem_stall_req) stalls++;
      step();
      chk({nm, " req held"}, 64'(mem_req_o), 64'(1'b1));
      chk({nm, " addr held"}, mem_addr_o, held_addr);
      chk({nm, " wait bubble"}, {55'h0, wb_rd_ena_o, wb_inst_type_o}, 64'h0);
    end
    mem_ack_i = 1'b1; mem_rdata_i = rdata;
    #1;
    if (mem_stall_req) stalls++;
    chk({nm, " ack-cycle stall"}, 64'(mem_stall_req), 64'(1'b0));
    step();
    idle_inputs();
    chk({nm, " req drop"}, 64'(mem_req_o), 64'(1'b0));
    chk({nm, " wb ena"}, 64'(wb_rd_ena_o), 64'(e_ena));
    chk({nm, " wb type"}, 64'(wb_inst_type_o), 64'(typ));
    chk({nm, " wb data"}, wb_rd_data_o, e_rd);
    if (!is_st) chk({nm, " wb addr"}, 64'(wb_rd_addr_o), 64'(ra));
    chk({nm, " stall cycles"}, 64'(stalls), 64'(e_stalls));
  endtask

  initial begin
    //        typ   ena ra  rd                     sel     addr                   ack | e_typ e_ena e_ra e_rd                  stall mis
    vt[0] = '{8'h10, 1'b1, 5'd5, 64'h1234,           3'b000, 64'h0,                 1'b0, 8'h10, 1'b1, 5'd5, 64'h1234,           1'b0, 1'b0};
    vt[1] = '{8'h20, 1'b1, 5'd0, 64'hFFFF_0000_1111_2222, 3'b011, 64'h7,            1'b0, 8'h20, 1'b1, 5'd0, 64'hFFFF_0000_1111_2222, 1'b0, 1'b0};
    vt[2] = '{8'h02, 1'b1, 5'd7, 64'h55,             3'b010, 64'h8000_0002,         1'b0, 8'h00, 1'b0, 5'd0, 64'h0,              1'b0, 1'b1};
    vt[3] = '{8'h01, 1'b0, 5'd3, 64'hABCD,           3'b001, 64'h8000_0001,         1'b0, 8'h00, 1'b0, 5'd0, 64'h0,              1'b0, 1'b1};
    vt[4] = '{8'h02, 1'b1, 5'd9, 64'h0,              3'b011, 64'h8000_0004,         1'b0, 8'h00, 1'b0, 5'd0, 64'h0,              1'b0, 1'b1};
    vt[5] = '{8'h40, 1'b1, 5'd12, 64'hCAFE,          3'b000, 64'h0,                 1'b1, 8'h40, 1'b1, 5'd12, 64'hCAFE,          1'b0, 1'b0};
    vt[6] = '{8'h80, 1'b0, 5'd31, 64'h77,            3'b110, 64'h8000_0003,         1'b0, 8'h80, 1'b0, 5'd31, 64'h77,            1'b0, 1'b0};

    idle_inputs();
    rst = 1'b1;
    step();
    step();
    chk("rst req", 64'(mem_req_o), 64'(1'b0));
    chk("rst bus", {mem_we_o, mem_wmask_o} | mem_addr_o | mem_wdata_o, 64'h0);
    chk("rst wb", {wb_rd_ena_o, wb_rd_addr_o, wb_inst_type_o} | wb_rd_data_o, 64'h0);
    chk("rst misalign", 64'(misalign_o), 64'(1'b0));
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      inst_type_i = vt[i].typ; rd_ena_i = vt[i].ena; rd_addr_i = vt[i].ra;
      rd_data_i = vt[i].rd; ls_sel_i = vt[i].sel; ls_addr_i = vt[i].addr;
      mem_ack_i = vt[i].ack; mem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      chk($sformatf("vec%0d stall", i), 64'(mem_stall_req), 64'(vt[i].e_stall));
      step();
      chk($sformatf("vec%0d wb type", i), 64'(wb_inst_type_o), 64'(vt[i].e_typ));
      chk($sformatf("vec%0d wb ena", i), 64'(wb_rd_ena_o), 64'(vt[i].e_ena));
      chk($sformatf("vec%0d wb addr", i), 64'(wb_rd_addr_o), 64'(vt[i].e_ra));
      chk($sformatf("vec%0d wb data", i), wb_rd_data_o, vt[i].e_rd);
      chk($sformatf("vec%0d misalign", i), 64'(misalign_o), 64'(vt[i].e_mis));
      chk($sformatf("vec%0d req", i), 64'(mem_req_o), 64'(1'b0));
    end
    idle_inputs();
    step();
    chk("misalign one-shot", 64'(misalign_o), 64'(1'b0));

    // byte 3 of 0x80FF0000 is 0x80, byte 2 is 0xFF
    run_mem("LB@3", 8'h02, 3'b000, 64'h8000_0003, 64'h0, 5'd10, 0, 64'h0000_0000_80FF_0000,
            1'b0, 8'h00, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1);
    run_mem("LB@2", 8'h02, 3'b000, 64'h8000_0002, 64'h0, 5'd11, 0, 64'h0000_0000_80FF_0000,
            1'b0, 8'h00, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_mem("LHU@6", 8'h02, 3'b101, 64'h8000_0006, 64'h0, 5'd12, 3, 64'hBEEF_0000_0000_0000,
            1'b0, 8'h00, 64'h0, 1'b1, 64'h0000_0000_0000_BEEF, 4);
    run_mem("LH@6", 8'h02, 3'b001, 64'h8000_0006, 64'h0, 5'd13, 0, 64'hBEEF_0000_0000_0000,
            1'b0, 8'h00, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_BEEF, 1);
    run_mem("LW@4", 8'h02, 3'b010, 64'h8000_0004, 64'h0, 5'd14, 1, 64'h8765_4321_0000_0000,
            1'b0, 8'h00, 64'h0, 1'b1, 64'hFFFF_FFFF_8765_4321, 2);
    run_mem("LD@8", 8'h02, 3'b011, 64'h8000_0008, 64'h0, 5'd15, 0, 64'h0123_4567_89AB_CDEF,
            1'b0, 8'h00, 64'h0, 1'b1, 64'h0123_4567_89AB_CDEF, 1);
    run_mem("LBU@1 type3", 8'h03, 3'b100, 64'h8000_0001, 64'h0, 5'd16, 0, 64'h0000_0000_0000_8000,
            1'b0, 8'h00, 64'h0, 1'b1, 64'h0000_0000_0000_0080, 1);
    run_mem("SW@4", 8'h01, 3'b010, 64'h8000_0004, 64'hDEAD_BEEF, 5'd0, 1, 64'h0,
            1'b1, 8'hF0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 64'h0, 2);
    run_mem("SB@5", 8'h01, 3'b000, 64'h8000_0005, 64'h1234_56AB, 5'd0, 0, 64'h0,
            1'b1, 8'h20, 64'hABAB_ABAB_ABAB_ABAB, 1'b0, 64'h0, 1);
    run_mem("SD@0", 8'h01, 3'b011, 64'h8000_0000, 64'h1122_3344_5566_7788, 5'd0, 0, 64'h0,
            1'b1, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, 64'h0, 1);

    // Reset while a load is outstanding, then a stale ack
    inst_type_i = 8'h02; rd_ena_i = 1'b1; rd_addr_i = 5'd20; ls_sel_i = 3'b011;
    ls_addr_i = 64'h8000_0008;
    step();
    chk("abort req before rst", 64'(mem_req_o), 64'(1'b1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    chk("abort req after rst", 64'(mem_req_o), 64'(1'b0));
    mem_ack_i = 1'b1; mem_rdata_i = 64'h1111_2222_3333_4444;
    #1;
    chk("late ack stall", 64'(mem_stall_req), 64'(1'b0));
    step();
    mem_ack_i = 1'b0;
    chk("late ack req", 64'(mem_req_o), 64'(1'b0));
    chk("late ack wb ena", 64'(wb_rd_ena_o), 64'(1'b0));
    chk("late ack wb data", wb_rd_data_o, 64'h0);
    step();
    chk("late ack wb idle", wb_rd_data_o | 64'(wb_rd_ena_o), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
